regfile_write_arbiter: RTL

Shares the register file's single write port between two sources: the in-order writeback stage and a long-latency result source (load-miss returns and mul/div completions). Long-latency results enter through a valid/ready handshake and are buffered in a small FIFO. The pipeline normally has priority. A starvation counter forces FIFO drains by stalling writeback. The block sits between the writeback unit and the register file write port.

---
 rtl/regfile_write_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between in-order writeback and a buffered long-latency source.
// Optional per-cycle trace and grant counters are built when REGFILE_ARB_REPORT_EN is defined.
module regfile_write_arbiter #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           wb_write,
  input  logic [4:0]                     wb_reg,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  output logic                           wb_stall,
  input  logic                           ll_valid,
  input  logic [4:0]                     ll_reg,
  input  logic [DATA_WIDTH-1:0]          ll_data,
  output logic                           ll_ready,
  output logic                           rf_write,
  output logic [4:0]                     rf_reg,
  output logic [DATA_WIDTH-1:0]          rf_data,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  input  logic                           report
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ST_W-1:0]  LIMIT_C = ST_W'(STARVE_LIMIT);

  logic [4:0]            mem_reg  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [ST_W-1:0]       starve_cnt;

  logic pipe_req, fifo_req, force_fifo;
  logic grant_wb, grant_fifo;
  logic enq, accept;

  assign ll_ready   = (fifo_count != DEPTH_C);
  assign accept     = ll_valid & ll_ready;
  // Writes to r0 complete the handshake but are dropped.
  assign enq        = accept & (ll_reg != 5'd0);
  assign pipe_req   = wb_write & (wb_reg != 5'd0);
  assign fifo_req   = (fifo_count != '0);
  assign force_fifo = fifo_req & (starve_cnt >= LIMIT_C);
  assign grant_fifo = force_fifo | (fifo_req & ~pipe_req);
  assign grant_wb   = pipe_req & ~force_fifo;
  assign wb_stall   = pipe_req & force_fifo;

  // Stage boundary: FIFO control, starvation tracking and the registered write port.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      starve_cnt <= '0;
      rf_write   <= 1'b0;
      rf_reg     <= 5'd0;
      rf_data    <= '0;
    end else begin
      if (enq)        wr_ptr <= wr_ptr + 1'b1;
      if (grant_fifo) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, grant_fifo})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (!fifo_req || grant_fifo)
        starve_cnt <= '0;
      else if (grant_wb && starve_cnt < LIMIT_C)
        starve_cnt <= starve_cnt + 1'b1;
      rf_write <= grant_wb | grant_fifo;
      if (grant_fifo) begin
        rf_reg  <= mem_reg[rd_ptr];
        rf_data <= mem_data[rd_ptr];
      end else if (grant_wb) begin
        rf_reg  <= wb_reg;
        rf_data <= wb_data;
      end else begin
        rf_reg  <= 5'd0;
        rf_data <= '0;
      end
    end
  end

  // Buffer storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clock) begin
    if (enq) begin
      mem_reg[wr_ptr]  <= ll_reg;
      mem_data[wr_ptr] <= ll_data;
    end
  end

`ifdef REGFILE_ARB_REPORT_EN
  logic [31:0] cycle_cnt, wb_grants, fifo_grants, force_grants;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycle_cnt    <= '0;
      wb_grants    <= '0;
      fifo_grants  <= '0;
      force_grants <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (grant_wb)   wb_grants    <= wb_grants + 32'd1;
      if (grant_fifo) fifo_grants  <= fifo_grants + 32'd1;
      if (force_fifo) force_grants <= force_grants + 32'd1;
      if (report) begin
        $display("[core %0d cycle %0d] grant=%s rf_write=%0b rf_reg=%0d rf_data=%0h",
                 CORE, cycle_cnt,
                 force_fifo ? "fifo(forced)" : grant_fifo ? "fifo" : grant_wb ? "wb" : "none",
                 rf_write, rf_reg, rf_data);
        $display("[core %0d cycle %0d] fifo_count=%0d starve_cnt=%0d wb_stall=%0b grants wb=%0d fifo=%0d forced=%0d",
                 CORE, cycle_cnt, fifo_count, starve_cnt, wb_stall,
                 wb_grants, fifo_grants, force_grants);
      end
    end
  end
`else
  logic unused_report;
  assign unused_report = report | (CORE < 0);
`endif

endmodule
